// File: rtl/spram_ctrl_if.sv
// Request/response handshake between an initiator (core/bridge) and spram_ctrl.
interface spram_ctrl_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 16
) ();
  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [AWIDTH-1:0]     req_addr;
  logic [DWIDTH-1:0]     req_wdata;
  logic [DWIDTH/8-1:0]   req_be;
  logic                  rsp_vld;
  logic [DWIDTH-1:0]     rsp_rdata;

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_be,
    input  req_rdy, rsp_vld, rsp_rdata
  );

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_be,
    output req_rdy, rsp_vld, rsp_rdata
  );
endinterface

// File: rtl/spram_ctrl.sv
// Single-port RAM initiator: reads, full writes, byte-masked RMW writes.
// Optional fill engine (auto-start after reset) under `SPRAM_CTRL_FILL_EN.
module spram_ctrl #(
  parameter int                DWIDTH       = 32,
  parameter int                AWIDTH       = 16,
  parameter logic [DWIDTH-1:0] FILL_PATTERN = 'h1234_7f7f
) (
  input  logic              clk,
  input  logic              rst_n,
  spram_ctrl_if.slave       bus,
  input  logic              fill_start,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_cen,
  output logic              ram_wen,
  output logic [DWIDTH-1:0] ram_din,
  input  logic [DWIDTH-1:0] ram_dout
);
  localparam int BW = DWIDTH / 8;

  typedef enum logic [2:0] {IDLE, RD, RD_CAP, RMW_RD, RMW_MRG, RMW_WR, FILL} state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] din_q, din_d, rdata_q, rdata_d, wdata_q, wdata_d, merged;
  logic [BW-1:0]     be_q, be_d;
  logic              cen_q, cen_d, wen_q, wen_d, rsp_vld_q, rsp_vld_d;
  logic              fill_go, accept, be_full, be_zero;

`ifdef SPRAM_CTRL_FILL_EN
  logic              pend_q, busy_q, busy_d, done_q, done_d;
  logic [AWIDTH:0]   cnt_q, cnt_d;

  // Auto-start looks like a fill_start pulse in the first cycle after reset.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pend_q <= 1'b0;
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
    end

  assign fill_go   = fill_start | pend_q;
  assign fill_busy = busy_q;
  assign fill_done = done_q;
`else
  logic unused_fill_start;
  assign unused_fill_start = fill_start;
  assign fill_go   = 1'b0;
  assign fill_busy = 1'b0;
  assign fill_done = 1'b0;
`endif

  assign bus.req_rdy   = (state_q == IDLE) & ~fill_go;
  assign accept        = bus.req_vld & bus.req_rdy;
  assign be_full       = &bus.req_be;
  assign be_zero       = ~|bus.req_be;
  assign bus.rsp_vld   = rsp_vld_q;
  assign bus.rsp_rdata = rdata_q;
  assign ram_addr      = addr_q;
  assign ram_cen       = cen_q;
  assign ram_wen       = wen_q;
  assign ram_din       = din_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      din_q     <= '0;
      rdata_q   <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      cen_q     <= 1'b1;
      wen_q     <= 1'b1;
      rsp_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      rdata_q   <= rdata_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      cen_q     <= cen_d;
      wen_q     <= wen_d;
      rsp_vld_q <= rsp_vld_d;
    end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fill_go)     state_d = FILL;
        else if (accept) begin
          if (!bus.req_wr)  state_d = RD;
          else if (be_full) state_d = RMW_WR;
          else if (be_zero) state_d = IDLE;
          else              state_d = RMW_RD;
        end
      end
      RD:      state_d = RD_CAP;
      RD_CAP:  state_d = IDLE;
      RMW_RD:  state_d = RMW_MRG;
      RMW_MRG: state_d = RMW_WR;
      RMW_WR:  state_d = IDLE;
`ifdef SPRAM_CTRL_FILL_EN
      FILL:    if (cnt_q[AWIDTH]) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // RAM has no byte enables: unmasked bytes come from the word just read.
  always_comb begin
    merged = '0;
    for (int k = 0; k < BW; k++)
      merged[8*k +: 8] = be_q[k] ? wdata_q[8*k +: 8] : ram_dout[8*k +: 8];
  end

  always_comb begin
    cen_d     = 1'b1;
    wen_d     = 1'b1;
    addr_d    = addr_q;
    din_d     = din_q;
    rsp_vld_d = 1'b0;
    rdata_d   = rdata_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
`ifdef SPRAM_CTRL_FILL_EN
    busy_d    = 1'b0;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = bus.req_addr;
          if (!bus.req_wr) cen_d = 1'b0;
          else if (be_full) begin
            cen_d     = 1'b0;
            wen_d     = 1'b0;
            din_d     = bus.req_wdata;
            rsp_vld_d = 1'b1;
            rdata_d   = '0;
          end else if (be_zero) begin
            rsp_vld_d = 1'b1;
            rdata_d   = '0;
          end else begin
            cen_d   = 1'b0;
            wdata_d = bus.req_wdata;
            be_d    = bus.req_be;
          end
        end
`ifdef SPRAM_CTRL_FILL_EN
        if (fill_go) begin
          cen_d  = 1'b0;
          wen_d  = 1'b0;
          addr_d = '0;
          din_d  = FILL_PATTERN;
          busy_d = 1'b1;
          cnt_d  = (AWIDTH+1)'(1);
        end
`endif
      end
      RD_CAP: begin
        rdata_d   = ram_dout;
        rsp_vld_d = 1'b1;
      end
      RMW_MRG: begin
        cen_d     = 1'b0;
        wen_d     = 1'b0;
        din_d     = merged;
        rsp_vld_d = 1'b1;
        rdata_d   = '0;
      end
`ifdef SPRAM_CTRL_FILL_EN
      // cnt_q holds the next address; its top bit marks all words written.
      FILL: begin
        if (cnt_q[AWIDTH]) done_d = 1'b1;
        else begin
          cen_d  = 1'b0;
          wen_d  = 1'b0;
          addr_d = cnt_q[AWIDTH-1:0];
          din_d  = FILL_PATTERN;
          busy_d = 1'b1;
          cnt_d  = cnt_q + (AWIDTH+1)'(1);
        end
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_spram_ctrl.sv
// Scoreboard bench for spram_ctrl: RAM model, reference memory, response/strobe queues.
module tb_spram_ctrl;
  localparam int DW = 32, AW = 4, BW = 4, N = 16;
  localparam logic [DW-1:0] PAT = 32'h1234_7f7f;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spram_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();
  logic          fill_start, fill_busy, fill_done, ram_cen, ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  spram_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .FILL_PATTERN(PAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .fill_start(fill_start), .fill_busy(fill_busy), .fill_done(fill_done),
    .ram_addr(ram_addr), .ram_cen(ram_cen), .ram_wen(ram_wen),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  logic [DW-1:0] mem [N];
  always @(posedge clk)
    if (!ram_cen) begin
      if (!ram_wen) mem[ram_addr] <= ram_din;
      else          ram_dout      <= mem[ram_addr];
    end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] d; int lat; int acc; } rsp_t;
  typedef struct { logic wen; logic [AW-1:0] a; logic [DW-1:0] d; } stb_t;
  rsp_t rq[$];
  stb_t sq[$];
  rsp_t mr;
  stb_t ms;
  logic [DW-1:0] ref_mem [N];
  int checks = 0, errors = 0;
  int fill_idx = 0, done_cnt = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) fill_idx = 0;
    else begin
      if (bus.rsp_vld) begin
        if (rq.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          mr = rq.pop_front();
          chk("rsp_data", bus.rsp_rdata, mr.d);
          chk("rsp_latency", cyc + 1 - mr.acc, mr.lat);
        end
      end
      if (!ram_cen) begin
        if (fill_busy) begin
          chk("fill_addr", ram_addr, fill_idx);
          chk("fill_strobe", {ram_wen, ram_din}, {1'b0, PAT});
          fill_idx++;
        end else if (sq.size() == 0) chk("strobe_unexpected", 1, 0);
        else begin
          ms = sq.pop_front();
          chk("strobe_wen", ram_wen, ms.wen);
          chk("strobe_addr", ram_addr, ms.a);
          if (!ms.wen) chk("strobe_din", ram_din, ms.d);
        end
      end
      if (fill_done) begin
        chk("fill_len", fill_idx, N);
        chk("fill_busy_at_done", fill_busy, 0);
        fill_idx = 0;
        done_cnt++;
      end
    end
  end

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [BW-1:0] be, output int acc);
    int t = 0;
    logic [DW-1:0] m;
    @(negedge clk);
    bus.req_vld = 1'b1; bus.req_wr = wr; bus.req_addr = a;
    bus.req_wdata = wd; bus.req_be = be;
    while (!bus.req_rdy && t < 100) begin @(negedge clk); t++; end
    acc = cyc + 1;
    if (t >= 100) begin
      chk("accept_timeout", 0, 1);
      bus.req_vld = 1'b0;
      return;
    end
    if (!wr) begin
      rq.push_back('{ref_mem[a], 3, acc});
      sq.push_back('{1'b1, a, '0});
    end else if (be == '1) begin
      ref_mem[a] = wd;
      sq.push_back('{1'b0, a, wd});
      rq.push_back('{'0, 1, acc});
    end else if (be == '0) begin
      rq.push_back('{'0, 1, acc});
    end else begin
      m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      ref_mem[a] = (wd & m) | (ref_mem[a] & ~m);
      sq.push_back('{1'b1, a, '0});
      sq.push_back('{1'b0, a, ref_mem[a]});
      rq.push_back('{'0, 3, acc});
    end
    @(posedge clk);
    #1 bus.req_vld = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((rq.size() != 0 || sq.size() != 0) && t < 50) begin @(negedge clk); t++; end
    chk("drain_timeout", t >= 50, 0);
  endtask

  task automatic wait_fill();
`ifdef SPRAM_CTRL_FILL_EN
    int t = 0;
    int d0 = done_cnt;
    for (int i = 0; i < N; i++) ref_mem[i] = PAT;
    while (done_cnt == d0 && t < 100) begin @(negedge clk); t++; end
    chk("fill_done_pulses", done_cnt - d0, 1);
`endif
  endtask

  task automatic check_reset_vals();
    chk("rst_rsp_vld", bus.rsp_vld, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_ram_cen", ram_cen, 1);
    chk("rst_ram_wen", ram_wen, 1);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_fill_busy", fill_busy, 0);
    chk("rst_fill_done", fill_done, 0);
  endtask

  int acc, s;
  logic [BW-1:0] rbe;

  initial begin
    for (int i = 0; i < N; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    bus.req_vld = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_be = '0; fill_start = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_vals();
`ifdef SPRAM_CTRL_FILL_EN
    chk("rst_req_rdy", bus.req_rdy, 0);
`else
    chk("rst_req_rdy", bus.req_rdy, 1);
`endif
    @(negedge clk) rst_n = 1'b1;
    wait_fill();

    // Full write, read back, partial write, zero-be write.
    issue(1'b1, 4'hA, 32'hDEADBEEF, 4'hF, acc);
    issue(1'b0, 4'hA, '0, 4'h0, acc);
    issue(1'b1, 4'hA, 32'h000000AA, 4'h1, acc);
    issue(1'b0, 4'hA, '0, 4'h0, acc);
    issue(1'b1, 4'hA, 32'h55555555, 4'h0, acc);
    drain();
    chk("zero_be_unchanged", mem[4'hA], 32'hDEADBEAA);

`ifdef SPRAM_CTRL_FILL_EN
    // fill_start wins over a simultaneous request, which is then held.
    @(negedge clk);
    fill_start = 1'b1;
    bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 4'hF; bus.req_be = '0;
    #1 chk("fill_prio_rdy", bus.req_rdy, 0);
    s = cyc + 1;
    @(posedge clk);
    #1 fill_start = 1'b0;
    for (int i = 0; i < N; i++) ref_mem[i] = PAT;
    issue(1'b0, 4'hF, '0, 4'h0, acc);
    chk("held_req_accept_edge", acc - s, N + 1);
    drain();
    chk("fill_word_f", mem[4'hF], PAT);
`endif

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0:       rbe = 4'hF;
        1:       rbe = 4'h0;
        default: rbe = 4'($urandom_range(1, 14));
      endcase
      issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, N - 1)), $urandom, rbe, acc);
    end
    drain();
    for (int i = 0; i < N; i++) chk("mem_contents", mem[i], ref_mem[i]);

    // Reset while the merged write is being prepared.
    @(negedge clk);
    bus.req_vld = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 4'h3;
    bus.req_wdata = 32'hA5A5A5A5; bus.req_be = 4'h2;
    chk("abort_rdy", bus.req_rdy, 1);
    sq.push_back('{1'b1, 4'h3, '0});
    @(posedge clk);
    #1 bus.req_vld = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_vals();
    repeat (2) @(posedge clk);
    #1 chk("abort_word_unchanged", mem[4'h3], ref_mem[4'h3]);
    chk("abort_no_pending_strobe", sq.size(), 0);
    @(negedge clk) rst_n = 1'b1;
    wait_fill();
    issue(1'b0, 4'h3, '0, 4'h0, acc);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
